// File: rtl/debounce_pkg.sv
//------------------------------------------------------------------------------
// Module   : debounce_pkg
// Brief    : Shared state encoding and default timing constant for the
//            push-button debouncer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } debounce_state_e;

    // 10 ms of stable input at a 100 MHz clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

`default_nettype wire

// File: rtl/bit_synchronizer.sv
//------------------------------------------------------------------------------
// Module   : bit_synchronizer
// Brief    : Multi-flop synchroniser for a single asynchronous level input.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/button_debouncer.sv
//------------------------------------------------------------------------------
// Module   : button_debouncer
// Brief    : Synchronises a bouncing button level and commits a level change
//            only after DEBOUNCE_CYCLES consecutive identical samples.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic db_out,
    output logic busy
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic            s;
    debounce_state_e state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            db_q;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (s)
    );

    // Any opposite sample in a WAIT state aborts; counts never carry over.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE_LOW: begin
                    if (s) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= IDLE_HIGH;
                        db_q    <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= CNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= IDLE_LOW;
                        db_q    <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    db_q    <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign db_out = db_q;
    assign busy   = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
//------------------------------------------------------------------------------
// Module   : tb_button_debouncer
// Brief    : Directed and randomized checks of button_debouncer against a
//            sample-history reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_debouncer;

    localparam int SYNC_STAGES = 2;
    localparam int DEB         = 4;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic btn_in = 1'b0;
    logic db_out;
    logic busy;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: raw samples delayed SYNC_STAGES edges, and the length
    // of the current run of samples that disagree with the committed level.
    bit pipe[$];
    bit m_db  = 1'b0;
    int m_run = 0;

    button_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_in),
        .db_out (db_out),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic b, input logic r);
        bit smp;
        btn_in = b;
        reset  = r;
        @(posedge clk);
        if (r) begin
            pipe.delete();
            repeat (SYNC_STAGES) pipe.push_back(1'b0);
            m_db  = 1'b0;
            m_run = 0;
        end else begin
            smp = pipe.pop_front();
            pipe.push_back(b);
            if (smp == m_db) m_run = 0;
            else             m_run++;
            if (m_run == DEB) begin
                m_db  = smp;
                m_run = 0;
            end
        end
        #1;
        chk("model_db_out", db_out, m_db);
        chk("model_busy", busy, m_run != 0);
    endtask

    initial begin
        int seg_len;
        bit lvl;

        // Reset with button held high: output stays low, then full requalify.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            chk("rst_db_out", db_out, 1'b0);
            chk("rst_busy", busy, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0);
            chk("post_rst_rise", db_out, i == 5);
        end

        // Release from high.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            chk("release_fall", db_out, i < 5);
        end
        repeat (2) step(1'b0, 1'b0);

        // Clean press.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0);
            chk("press_db_out", db_out, i == 5);
            chk("press_busy", busy, (i >= 2) && (i < 5));
        end
        repeat (2) step(1'b1, 1'b0);

        // Three-cycle low glitch while high leaves output high.
        repeat (3) step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            chk("low_glitch_hold", db_out, 1'b1);
        end

        // Settle low, then a two-cycle high glitch.
        repeat (10) step(1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0);
            chk("high_glitch_hold", db_out, 1'b0);
        end
        chk("high_glitch_idle", busy, 1'b0);

        // Bounce 1,0,1,1,0 then steady 1: rise 6 edges after the last 0->1.
        begin
            bit bounce [0:4];
            bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 12; i++) begin
                step((i < 5) ? bounce[i] : 1'b1, 1'b0);
                chk("bounce_rise", db_out, i >= 10);
            end
        end

        // Reset in the middle of a rising qualification.
        repeat (8) step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        chk("mid_wait_busy", busy, 1'b1);
        step(1'b1, 1'b1);
        chk("mid_wait_rst_db", db_out, 1'b0);
        chk("mid_wait_rst_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0);
            chk("requalify_rise", db_out, i == 5);
        end

        // Randomized segments of held levels with occasional resets.
        lvl = 1'b1;
        for (int seg = 0; seg < 400; seg++) begin
            lvl     = ($urandom_range(0, 3) == 0) ? lvl : ~lvl;
            seg_len = $urandom_range(1, 8);
            for (int k = 0; k < seg_len; k++) begin
                step(lvl, ($urandom_range(0, 60) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for the Mealy rising-edge detector.
- Takes a raw, asynchronous, bouncing push-button level and synchronises it into clk.
- Qualifies each level change over a programmable number of consecutive stable samples.
- Drives a clean, glitch-free level on db_out, which feeds the edge detector's ain input.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on btn_in; legal range >= 2.
- DEBOUNCE_CYCLES, 1000000, consecutive identical synchronised samples needed to commit a level change (10 ms at 100 MHz); legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), derived localparam; width of the stability counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- btn_in, input, 1, raw button level; asynchronous to clk and may bounce.
- db_out, output, 1, debounced level, registered.
- busy, output, 1, high while a candidate level change is being qualified; decoded from the state register.

Behaviour:
- Clocking and reset:
  - Clock is clk; reset is reset, synchronous, active-high.
  - On any edge with reset=1: synchroniser chain <= 0, state <= IDLE_LOW, cnt <= 0, db_out <= 0.
  - busy is 0 after that edge. Reset overrides every other event.
- Synchroniser:
  - btn_in passes through SYNC_STAGES flops to produce s, the only signal the FSM samples.
  - btn_in has no other fanout.
- FSM states (2-bit encoding): IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- IDLE_LOW (db_out=0):
  - s=1 -> WAIT_HIGH, cnt <= 1.
  - Otherwise hold.
- WAIT_HIGH (db_out=0):
  - s=0 -> IDLE_LOW, cnt <= 0 (glitch rejected).
  - s=1 and cnt==DEBOUNCE_CYCLES-1 -> IDLE_HIGH, db_out <= 1, cnt <= 0.
  - Otherwise cnt <= cnt+1.
- IDLE_HIGH (db_out=1):
  - s=0 -> WAIT_LOW, cnt <= 1.
  - Otherwise hold.
- WAIT_LOW (db_out=1):
  - s=1 -> IDLE_HIGH, cnt <= 0.
  - s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE_LOW, db_out <= 0, cnt <= 0.
  - Otherwise cnt <= cnt+1.
- Unreachable encodings: any illegal state value goes to IDLE_LOW, db_out <= 0, cnt <= 0.
- busy: 1 in WAIT_HIGH and WAIT_LOW, 0 otherwise.
- Latency:
  - btn_in changes and stays stable before edge e0.
  - s reflects the change after edge e0+SYNC_STAGES-1.
  - The FSM first sees it at edge e0+SYNC_STAGES.
  - db_out changes after edge e0+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - With defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=4 (test values): e0+5.
- Counter: never exceeds DEBOUNCE_CYCLES-1; no wrap possible.
- Bounce handling:
  - Any opposite sample in a WAIT state aborts the qualification.
  - The next change restarts at cnt=1; counts are never accumulated across aborts.
- Glitch guarantee: db_out never pulses for less than DEBOUNCE_CYCLES cycles.
- Reset mid-qualification or while db_out=1:
  - db_out drops to 0 on the reset edge.
  - A held button requalifies with full latency once reset is released, because the synchroniser is cleared.

Decomposition:
- Shared package debounce_pkg:
  - State typedef (2-bit enum: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW).
  - Default DEBOUNCE_CYCLES constant.
- One natural sub-module: bit_synchronizer.
  - Parameter STAGES.
  - Ports clk, reset, d, q.
  - Synchronous active-high reset to 0.
  - Reusable for other asynchronous inputs.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset with btn_in=1 held for 3 edges -> db_out=0, busy=0 throughout. After release, db_out=1 exactly 6 edges later.
- Clean press: btn_in 0->1 before edge e0, held -> busy=1 after e0+2. db_out=1 and busy=0 after e0+5; db_out=0 before that edge.
- Glitch: btn_in high for 2 cycles, then low -> busy pulses, db_out stays 0, FSM back in IDLE_LOW.
- Bounce: btn_in 1,0,1,1,0 then steady 1 -> db_out rises exactly 6 edges after the final 0->1 transition; no earlier pulse.
- Release: from db_out=1, btn_in 1->0 held -> db_out=0 after e0+5. A 3-cycle low glitch instead leaves db_out=1.
- Reset mid-WAIT_HIGH (cnt=2) with btn_in held 1 -> db_out=0 on the reset edge; after release, qualification takes the full 6 edges again.
